tx_pkt_feeder: RTL and testbench

Upstream packet source for the DCFEB transmit frame processor. Buffers 16-bit data words from the readout path in a circular buffer. Once a full packet is held, it asserts VALID to start a frame, waits for TX_ACK, and then streams exactly PKT_WORDS words so they line up with the frame FSM's Strt_Data/Data states (the CRC_DV window). Between packets it enforces an inter-frame gap.

---
 rtl/tx_pkt_feeder_pkg.sv | 22 ++
 rtl/tx_pkt_buf.sv | 53 +++++
 rtl/tx_pkt_feeder.sv | 177 +++++++++++++++++
 tb/tb_tx_pkt_feeder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkt_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pkt_feeder_pkg
//  Description : Shared defaults and the control FSM state encoding for the
//                tx_pkt_feeder packet source.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_pkt_feeder_pkg;

    localparam int c_DATA_W = 16;   // default data word width
    localparam int c_ADDR_W = 10;   // default buffer address width

    // Control FSM states
    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage : tx_pkt_feeder_pkg
`default_nettype wire

// File: rtl/tx_pkt_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pkt_buf
//  Description : Simple dual-port packet RAM, 2**ADDR_W x DATA_W.
//                Synchronous write port; synchronous read port whose output
//                register is the feeder's DOUT register (holds when idle).
//  Ports       : clk        - clock
//                rst        - synchronous active-high reset (output reg only)
//                i_we       - write enable
//                i_wr_addr  - write address
//                i_wr_data  - write data
//                i_rd_en    - read enable, loads o_rd_data
//                i_rd_addr  - read address
//                o_rd_data  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_pkt_buf #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rd_data_q;

    // Array kept free of reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output register resets to zero and holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data_q <= '0;
        end else if (i_rd_en) begin
            r_rd_data_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data_q;

endmodule : tx_pkt_buf
`default_nettype wire

// File: rtl/tx_pkt_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pkt_feeder
//  Description : Circular-buffer packet source for the DCFEB transmit frame
//                processor. Requests a frame with VALID once PKT_WORDS are
//                buffered, waits for TX_ACK, streams PKT_WORDS words aligned
//                to the frame FSM data window, then holds an inter-frame gap.
//  Ports       : CLK, RST   - clock, synchronous active-high reset
//                DIN/DIN_WE - write data and strobe
//                CLR_OVFL   - clears the sticky overflow flag
//                TX_ACK     - frame start acknowledge
//                VALID      - packet request / stream-continue
//                DOUT/DOUT_DV - registered packet data and its valid
//                WORD_CNT   - buffered word count
//                FULL/OVFL  - buffer full, sticky dropped-write flag
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_pkt_feeder
    import tx_pkt_feeder_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int ADDR_W    = c_ADDR_W,
    parameter int PKT_WORDS = 100,
    parameter int IFG_CYC   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_WE,
    input  logic              CLR_OVFL,
    input  logic              TX_ACK,
    output logic              VALID,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_DV,
    output logic [ADDR_W:0]   WORD_CNT,
    output logic              FULL,
    output logic              OVFL
);

    localparam int c_PTR_W = ADDR_W + 1;
    localparam int c_GAP_W = $clog2(IFG_CYC) + 1;

    localparam logic [c_PTR_W-1:0] c_DEPTH    = c_PTR_W'(2**ADDR_W);
    localparam logic [c_PTR_W-1:0] c_PKT      = c_PTR_W'(PKT_WORDS);
    localparam logic [c_PTR_W-1:0] c_PKT_LAST = c_PTR_W'(PKT_WORDS - 1);
    // GAP lasts IFG_CYC-1 cycles; the mandatory WAIT cycle completes the gap
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(IFG_CYC - 1);

    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PTR_W-1:0] r_sent_q,   w_sent_d;
    logic [c_GAP_W-1:0] r_gap_q,    w_gap_d;
    logic               r_ovfl_q,   w_ovfl_d;
    logic               r_valid_q,  w_valid_d;
    logic               r_dout_dv_q, w_dout_dv_d;
    state_t             r_state_q,  w_state_d;

    logic [c_PTR_W-1:0] w_word_cnt;
    logic               w_full;
    logic               w_wr_en;
    logic               w_rd_en;

    // ------------------------------------------------------------------
    // Buffer bookkeeping: FULL is judged before any same-cycle read
    // ------------------------------------------------------------------
    always_comb begin
        w_word_cnt = r_wr_ptr_q - r_rd_ptr_q;
        w_full     = (w_word_cnt == c_DEPTH);
        w_wr_en    = DIN_WE & ~w_full;
        // A new drop wins over a simultaneous clear
        w_ovfl_d   = (r_ovfl_q & ~CLR_OVFL) | (DIN_WE & w_full);
        w_wr_ptr_d = w_wr_en ? (r_wr_ptr_q + 1'b1) : r_wr_ptr_q;
    end

    // ------------------------------------------------------------------
    // Control FSM next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_valid_d   = r_valid_q;
        w_dout_dv_d = r_dout_dv_q;
        w_sent_d    = r_sent_q;
        w_gap_d     = r_gap_q;
        w_rd_en     = 1'b0;

        case (r_state_q)
            ST_WAIT: begin
                w_valid_d = 1'b0;
                if (w_word_cnt >= c_PKT) begin
                    w_state_d = ST_REQ;
                    w_valid_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (TX_ACK) begin
                    w_rd_en     = 1'b1;
                    w_dout_dv_d = 1'b1;
                    w_sent_d    = c_PTR_W'(1);
                    w_state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_sent_q == c_PKT) begin
                    // DOUT currently carries the last word
                    w_dout_dv_d = 1'b0;
                    w_gap_d     = c_GAP_W'(1);
                    w_state_d   = ST_GAP;
                end else begin
                    w_rd_en  = 1'b1;
                    w_sent_d = r_sent_q + 1'b1;
                    // Drop VALID as the final word is loaded so the frame
                    // FSM leaves Data right after it
                    if (r_sent_q == c_PKT_LAST) begin
                        w_valid_d = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_q == c_GAP_LAST) begin
                    w_state_d = ST_WAIT;
                end else begin
                    w_gap_d = r_gap_q + 1'b1;
                end
            end
            default: begin
                w_state_d = ST_WAIT;
                w_valid_d = 1'b0;
            end
        endcase

        w_rd_ptr_d = w_rd_en ? (r_rd_ptr_q + 1'b1) : r_rd_ptr_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_sent_q    <= '0;
            r_gap_q     <= '0;
            r_ovfl_q    <= 1'b0;
            r_valid_q   <= 1'b0;
            r_dout_dv_q <= 1'b0;
            r_state_q   <= ST_WAIT;
        end else begin
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_sent_q    <= w_sent_d;
            r_gap_q     <= w_gap_d;
            r_ovfl_q    <= w_ovfl_d;
            r_valid_q   <= w_valid_d;
            r_dout_dv_q <= w_dout_dv_d;
            r_state_q   <= w_state_d;
        end
    end

    tx_pkt_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (CLK),
        .rst       (RST),
        .i_we      (w_wr_en),
        .i_wr_addr (r_wr_ptr_q[ADDR_W-1:0]),
        .i_wr_data (DIN),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr_q[ADDR_W-1:0]),
        .o_rd_data (DOUT)
    );

    assign VALID    = r_valid_q;
    assign DOUT_DV  = r_dout_dv_q;
    assign WORD_CNT = w_word_cnt;
    assign FULL     = w_full;
    assign OVFL     = r_ovfl_q;

endmodule : tx_pkt_feeder
`default_nettype wire

// File: tb/tb_tx_pkt_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_pkt_feeder
//  Description : Directed self-checking bench. Instance A uses the default
//                geometry (1024 words, 100-word packets); instance B uses a
//                16-word buffer with 8-word packets for full/overflow cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_pkt_feeder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic        rst_a, we_a, clr_a, ack_a;
    logic [15:0] din_a;
    logic        valid_a, dv_a, full_a, ovfl_a;
    logic [15:0] dout_a;
    logic [10:0] cnt_a;

    // Instance B
    logic        rst_b, we_b, clr_b, ack_b;
    logic [15:0] din_b;
    logic        valid_b, dv_b, full_b, ovfl_b;
    logic [15:0] dout_b;
    logic [4:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    tx_pkt_feeder #(.DATA_W(16), .ADDR_W(10), .PKT_WORDS(100), .IFG_CYC(4)) u_dut_a (
        .CLK(clk), .RST(rst_a), .DIN(din_a), .DIN_WE(we_a), .CLR_OVFL(clr_a),
        .TX_ACK(ack_a), .VALID(valid_a), .DOUT(dout_a), .DOUT_DV(dv_a),
        .WORD_CNT(cnt_a), .FULL(full_a), .OVFL(ovfl_a)
    );

    tx_pkt_feeder #(.DATA_W(16), .ADDR_W(4), .PKT_WORDS(8), .IFG_CYC(4)) u_dut_b (
        .CLK(clk), .RST(rst_b), .DIN(din_b), .DIN_WE(we_b), .CLR_OVFL(clr_b),
        .TX_ACK(ack_b), .VALID(valid_b), .DOUT(dout_b), .DOUT_DV(dv_b),
        .WORD_CNT(cnt_b), .FULL(full_b), .OVFL(ovfl_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_a(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            din_a = 16'(base + i);
            we_a  = 1'b1;
            step();
        end
        we_a = 1'b0;
    endtask

    task automatic wait_valid_a();
        for (int k = 0; k < 300 && valid_a !== 1'b1; k++) step();
        chk("valid_wait", 32'(valid_a), 32'd1);
    endtask

    // Frame FSM behaviour: SOP the cycle after VALID is seen, then TX_ACK
    task automatic frame_a(input int base);
        int dvn;
        wait_valid_a();
        step();                 // SOP
        step();                 // SOF_TX_Ack
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
        dvn = 0;
        for (int i = 0; i < 100; i++) begin
            chk("frm_dout",  32'(dout_a),  32'(base + i));
            chk("frm_valid", 32'(valid_a), 32'(i != 99));
            if (dv_a === 1'b1) dvn++;
            step();
        end
        chk("frm_dv_count", 32'(dvn), 32'd100);
        chk("frm_dv_after", 32'(dv_a), 32'd0);
    endtask

    initial begin
        int low_cyc;
        rst_a = 1'b1; we_a = 1'b0; clr_a = 1'b0; ack_a = 1'b0; din_a = '0;
        rst_b = 1'b1; we_b = 1'b0; clr_b = 1'b0; ack_b = 1'b0; din_b = '0;
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_dout",  32'(dout_a),  32'd0);
        chk("rst_dv",    32'(dv_a),    32'd0);
        chk("rst_cnt",   32'(cnt_a),   32'd0);
        chk("rst_full",  32'(full_a),  32'd0);
        chk("rst_ovfl",  32'(ovfl_a),  32'd0);

        // ---- B: fill 16-deep buffer, 17th write dropped ----
        for (int i = 0; i < 17; i++) begin
            din_b = 16'(i);
            we_b  = 1'b1;
            step();
            if (i == 15) begin
                chk("b_full16",  32'(full_b), 32'd1);
                chk("b_cnt16",   32'(cnt_b),  32'd16);
                chk("b_ovfl16",  32'(ovfl_b), 32'd0);
            end
        end
        we_b = 1'b0;
        chk("b_ovfl17", 32'(ovfl_b), 32'd1);
        chk("b_cnt17",  32'(cnt_b),  32'd16);
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        chk("b_clr", 32'(ovfl_b), 32'd0);

        // ---- B: write while FULL on the reading edge is dropped ----
        chk("b_valid", 32'(valid_b), 32'd1);
        ack_b = 1'b1;
        we_b  = 1'b1;
        din_b = 16'hBEEF;
        step();
        ack_b = 1'b0;
        we_b  = 1'b0;
        chk("b_rw_ovfl", 32'(ovfl_b), 32'd1);
        chk("b_rw_cnt",  32'(cnt_b),  32'd15);
        chk("b_rw_dv",   32'(dv_b),   32'd1);
        chk("b_rw_dout", 32'(dout_b), 32'd0);

        // ---- A: TX_ACK in WAIT is ignored ----
        write_a(0, 10);
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
        chk("ign_dv",    32'(dv_a),    32'd0);
        chk("ign_cnt",   32'(cnt_a),   32'd10);
        chk("ign_valid", 32'(valid_a), 32'd0);

        // ---- A: 100-word packet, words 0..99 ----
        write_a(10, 90);
        chk("req_delay", 32'(valid_a), 32'd0);
        step();
        chk("req_rise",  32'(valid_a), 32'd1);
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            chk("p1_dout",  32'(dout_a),  32'(i));
            chk("p1_dv",    32'(dv_a),    32'd1);
            chk("p1_valid", 32'(valid_a), 32'(i != 99));
            step();
        end
        chk("p1_dv_end",  32'(dv_a),   32'd0);
        chk("p1_hold",    32'(dout_a), 32'd99);
        chk("p1_cnt_end", 32'(cnt_a),  32'd0);

        // ---- A: closed loop, 250 words -> two frames, 50 left ----
        write_a(0, 250);
        frame_a(0);
        low_cyc = 0;
        for (int k = 0; k < 20 && valid_a !== 1'b1; k++) begin
            low_cyc++;
            step();
        end
        chk("ifg_low", 32'(low_cyc), 32'd4);
        frame_a(100);
        chk("left50", 32'(cnt_a), 32'd50);

        // ---- A: reset at word 40 of a packet ----
        write_a(250, 50);
        wait_valid_a();
        step();
        step();
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
        for (int i = 0; i < 40; i++) step();
        chk("mid_word40", 32'(dout_a), 32'd240);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("mid_valid", 32'(valid_a), 32'd0);
        chk("mid_dv",    32'(dv_a),    32'd0);
        chk("mid_cnt",   32'(cnt_a),   32'd0);
        chk("mid_ovfl",  32'(ovfl_a),  32'd0);
        step();
        step();
        chk("mid_wait",  32'(valid_a), 32'd0);

        // Clean packet after the reset
        write_a(1000, 100);
        frame_a(1000);
        chk("post_cnt", 32'(cnt_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tx_pkt_feeder
`default_nettype wire
